// File: rtl/arb_pkt_requester.sv
// Source-side agent for the round-robin arbiter: buffers whole packets in a FIFO,
// requests the shared bus once a complete packet is stored, and streams it while granted.
module arb_pkt_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_AW        = 4,
  parameter int STARVE_CNT_MAX = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] inData_i,
  input  logic                  inValid_i,
  input  logic                  inLast_i,
  output logic                  inReady_o,
  output logic                  req_o,
  input  logic                  grant_i,
  output logic [DATA_WIDTH-1:0] outData_o,
  output logic                  outValid_o,
  output logic                  outLast_o,
  output logic [FIFO_AW:0]      pktCount_o,
  output logic                  starved_o,
  output logic                  overflow_o,
  input  logic                  clrStatus_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(STARVE_CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_CNT_MAX);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_AW:0]   PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [FIFO_AW:0]    wrPtr_q, wrPtr_d;
  logic [FIFO_AW:0]    rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]    pktCount_q, pktCount_d;
  logic [CNT_W-1:0]    starveCnt_q, starveCnt_d;
  logic                starved_q, starved_d;
  logic                overflow_q, overflow_d;

  logic                full;
  logic                empty;
  logic                wrEn;
  logic                pop;
  logic                pktIn;
  logic                pktOut;
  logic [DATA_WIDTH:0] headWord;
  logic                headLast;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign full     = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                    (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);
  assign empty    = (wrPtr_q == rdPtr_q);
  assign wrEn     = inValid_i && !full;
  assign headWord = mem_q[rdPtr_q[FIFO_AW-1:0]];
  assign headLast = headWord[DATA_WIDTH];
  assign pop      = (state_q == REQ) && grant_i && !empty;
  assign pktIn    = wrEn && inLast_i;
  assign pktOut   = pop && headLast;

  assign inReady_o  = !full;
  assign req_o      = (state_q == REQ);
  assign outValid_o = pop;
  assign outData_o  = headWord[DATA_WIDTH-1:0];
  assign outLast_o  = pktOut;
  assign pktCount_o = pktCount_q;
  assign starved_o  = starved_q;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      mem_q[wrPtr_q[FIFO_AW-1:0]] <= {inLast_i, inData_i};
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    pktCount_d = pktCount_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({pktIn, pktOut})
      2'b10:   pktCount_d = pktCount_q + PTR_ONE;
      2'b01:   pktCount_d = pktCount_q - PTR_ONE;
      default: pktCount_d = pktCount_q;
    endcase
  end

  // A set condition in the same cycle as clrStatus leaves the flag set.
  always_comb begin
    starveCnt_d = '0;
    if (req_o && !grant_i) begin
      starveCnt_d = (starveCnt_q == STARVE_MAX) ? starveCnt_q : starveCnt_q + CNT_ONE;
    end
    starved_d  = clrStatus_i ? 1'b0 : starved_q;
    overflow_d = clrStatus_i ? 1'b0 : overflow_q;
    if (starveCnt_d == STARVE_MAX) begin
      starved_d = 1'b1;
    end
    if (inValid_i && full) begin
      overflow_d = 1'b1;
    end
  end

  // GAP holds req low for a single cycle; a pending packet re-requests right after it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pktCount_q != '0) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (pktOut) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = (pktCount_q != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      pktCount_q  <= '0;
      starveCnt_q <= '0;
      starved_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      pktCount_q  <= pktCount_d;
      starveCnt_q <= starveCnt_d;
      starved_q   <= starved_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
